// File: rtl/load_store_unit_if.sv
// -----------------------------------------------------------------------------
// load_store_unit_if
//
// Data-memory bus between the load/store unit and data memory. One
// request/acknowledge transaction is outstanding at a time.
//
// Signals:
//   mem_req    LSU -> mem   request, held high until mem_ack
//   mem_we     LSU -> mem   1 = write, 0 = read
//   mem_addr   LSU -> mem   word-aligned byte address
//   mem_wdata  LSU -> mem   lane-replicated store data
//   mem_be     LSU -> mem   byte enables (little-endian lanes)
//   mem_rdata  mem -> LSU   read word, sampled on mem_ack
//   mem_ack    mem -> LSU   single-cycle completion strobe
//
// Modports:
//   master  the load/store unit side
//   slave   the data memory side
// -----------------------------------------------------------------------------
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output mem_be,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  mem_be,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Data-memory access stage of the MIPS datapath, sitting between the ALU and
// the memtoreg writeback select. An aligned load or store presented on the
// pipeline inputs launches one request/acknowledge transaction on the memory
// bus; the upstream pipeline is stalled until the transaction finishes. Load
// data is lane-selected (byte/half/word) and sign- or zero-extended before it
// is registered onto rdata.
//
// Parameters:
//   TIMEOUT       cycles spent in REQ without mem_ack before the access is
//                 abandoned with bus_err (1..65535)
//
// Ports:
//   clk           clock, rising edge
//   rst           synchronous active-high reset
//   memread       load requested this cycle
//   memwrite      store requested this cycle (wins over memread)
//   mem_size      00 byte, 01 half, 10/11 word
//   mem_unsigned  1 = zero-extend load, 0 = sign-extend
//   addr          byte address from the ALU
//   wdata         store data (rt)
//   rdata         formatted load data to the writeback select
//   stall         hold upstream pipeline registers (combinational)
//   misaligned    address exception (combinational)
//   bus_err       timeout flag, high only during the DONE cycle
//   mem           data-memory bus, master side
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      memread,
    input  logic                      memwrite,
    input  logic [1:0]                mem_size,
    input  logic                      mem_unsigned,
    input  logic [31:0]               addr,
    input  logic [31:0]               wdata,
    output logic [31:0]               rdata,
    output logic                      stall,
    output logic                      misaligned,
    output logic                      bus_err,
    load_store_unit_if.master         mem
);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;

    // Last counter value that still waits for an ack; reaching it without an
    // ack abandons the access, so REQ lasts at most TIMEOUT cycles.
    localparam logic [15:0] COUNT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] count;

    // Registered bus outputs.
    logic        req_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;

    // Captured attributes of the outstanding access, needed to format the
    // load word when the ack arrives.
    logic        is_load_q;
    logic [1:0]  lane_q;
    logic [1:0]  size_q;
    logic        unsigned_q;

    logic        op;
    logic        size_is_half;
    logic        size_is_word;

    // -------------------------------------------------------------------------
    // Lane helpers
    // -------------------------------------------------------------------------

    function automatic logic [3:0] lane_enables(input logic [1:0] size,
                                                input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = 4'b0001 << lane;
            SIZE_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            default:   be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data is replicated across every lane so memory only needs to
    // honour the byte enables, never shift.
    function automatic logic [31:0] replicate_store(input logic [1:0]  size,
                                                    input logic [31:0] data);
        logic [31:0] r;
        case (size)
            SIZE_BYTE: r = {4{data[7:0]}};
            SIZE_HALF: r = {2{data[15:0]}};
            default:   r = data;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] format_load(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [1:0]  size,
                                                input logic        zext);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SIZE_BYTE: r = {{24{~zext & b[7]}}, b};
            SIZE_HALF: r = {{16{~zext & h[15]}}, h};
            default:   r = word;
        endcase
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Combinational pipeline controls
    // -------------------------------------------------------------------------

    assign op           = memread | memwrite;
    assign size_is_half = (mem_size == SIZE_HALF);
    assign size_is_word = mem_size[1];

    assign misaligned = op & ((size_is_half & addr[0]) |
                              (size_is_word & (addr[1:0] != 2'b00)));

    // Stall drops in DONE so the instruction that owned the access advances.
    assign stall = op & ~misaligned & (state != DONE);

    // -------------------------------------------------------------------------
    // Transaction FSM
    // -------------------------------------------------------------------------

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= 16'd0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            be_q       <= 4'd0;
            bus_err    <= 1'b0;
            rdata      <= 32'd0;
            is_load_q  <= 1'b0;
            lane_q     <= 2'd0;
            size_q     <= 2'd0;
            unsigned_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus_err <= 1'b0;
                    // Any mem_ack seen here is stale and deliberately ignored.
                    if (op && !misaligned) begin
                        addr_q     <= {addr[31:2], 2'b00};
                        we_q       <= memwrite;
                        be_q       <= lane_enables(mem_size, addr[1:0]);
                        wdata_q    <= replicate_store(mem_size, wdata);
                        is_load_q  <= ~memwrite;
                        lane_q     <= addr[1:0];
                        size_q     <= mem_size;
                        unsigned_q <= mem_unsigned;
                        count      <= 16'd0;
                        req_q      <= 1'b1;
                        state      <= REQ;
                    end
                end

                REQ: begin
                    // An ack in the final allowed cycle still completes
                    // normally; the timeout only fires without one.
                    if (mem.mem_ack) begin
                        if (is_load_q) begin
                            rdata <= format_load(mem.mem_rdata, lane_q,
                                                 size_q, unsigned_q);
                        end
                        req_q <= 1'b0;
                        state <= DONE;
                    end else if (count == COUNT_LAST) begin
                        if (is_load_q) begin
                            rdata <= 32'd0;
                        end
                        bus_err <= 1'b1;
                        req_q   <= 1'b0;
                        state   <= DONE;
                    end else begin
                        count <= count + 16'd1;
                    end
                end

                DONE: begin
                    bus_err <= 1'b0;
                    state   <= IDLE;
                end

                default: begin
                    bus_err <= 1'b0;
                    req_q   <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_be    = be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Directed bench for load_store_unit with TIMEOUT = 4. Expected load results
// and error flags are pushed to a scoreboard queue when an access is driven
// and popped when the unit reaches its completion cycle.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        memread;
    logic        memwrite;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        misaligned;
    logic        bus_err;

    load_store_unit_if bus ();

    load_store_unit #(.TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .memread      (memread),
        .memwrite     (memwrite),
        .mem_size     (mem_size),
        .mem_unsigned (mem_unsigned),
        .addr         (addr),
        .wdata        (wdata),
        .rdata        (rdata),
        .stall        (stall),
        .misaligned   (misaligned),
        .bus_err      (bus_err),
        .mem          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one access at the next falling edge and follows it to
    // completion. ack_after selects the REQ cycle (0-based) that gets mem_ack;
    // a negative value never acknowledges.
    task automatic do_access(input string tag,
                             input logic rd, input logic wr,
                             input logic [1:0] size, input logic uns,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] mrd, input int ack_after,
                             input logic [31:0] exp_addr, input logic [3:0] exp_be,
                             input logic [31:0] exp_wdata, input logic exp_we,
                             input logic [31:0] exp_rdata, input logic exp_err,
                             input int exp_stall);
        int   stalls;
        int   reqs;
        bit   done;
        exp_t e;
        stalls = 0;
        reqs   = 0;
        done   = 1'b0;
        @(negedge clk);
        memread      = rd;
        memwrite     = wr;
        mem_size     = size;
        mem_unsigned = uns;
        addr         = a;
        wdata        = wd;
        bus.mem_ack  = 1'b0;
        bus.mem_rdata = ~mrd;
        sb.push_back({exp_rdata, exp_err});
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            #1;
            if (cyc == 0) check({tag, ".misaligned"}, {31'd0, misaligned}, 32'd0);
            if (!stall) begin
                done = 1'b1;
                e = sb.pop_front();
                check({tag, ".rdata"},   rdata,               e.rdata);
                check({tag, ".bus_err"}, {31'd0, bus_err},    {31'd0, e.err});
                check({tag, ".req_off"}, {31'd0, bus.mem_req}, 32'd0);
                check({tag, ".stalls"},  stalls,              exp_stall);
                memread     = 1'b0;
                memwrite    = 1'b0;
                bus.mem_ack = 1'b0;
            end else begin
                stalls++;
                if (bus.mem_req) begin
                    check({tag, ".mem_addr"},  bus.mem_addr,        exp_addr);
                    check({tag, ".mem_be"},    {28'd0, bus.mem_be}, {28'd0, exp_be});
                    check({tag, ".mem_wdata"}, bus.mem_wdata,       exp_wdata);
                    check({tag, ".mem_we"},    {31'd0, bus.mem_we}, {31'd0, exp_we});
                    bus.mem_ack   = (reqs == ack_after);
                    bus.mem_rdata = bus.mem_ack ? mrd : ~mrd;
                    reqs++;
                end else begin
                    bus.mem_ack = 1'b0;
                end
                @(negedge clk);
            end
        end
        if (!done) begin
            check({tag, ".completion"}, 32'd0, 32'd1);
            if (sb.size() != 0) void'(sb.pop_front());
            memread     = 1'b0;
            memwrite    = 1'b0;
            bus.mem_ack = 1'b0;
        end
        @(negedge clk);
        #1;
        check({tag, ".idle_err"},   {31'd0, bus_err}, 32'd0);
        check({tag, ".idle_stall"}, {31'd0, stall},   32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        memread       = 1'b0;
        memwrite      = 1'b0;
        mem_size      = 2'b10;
        mem_unsigned  = 1'b0;
        addr          = 32'd0;
        wdata         = 32'd0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        check("reset.rdata",     rdata,                 32'd0);
        check("reset.mem_req",   {31'd0, bus.mem_req},  32'd0);
        check("reset.mem_we",    {31'd0, bus.mem_we},   32'd0);
        check("reset.mem_addr",  bus.mem_addr,          32'd0);
        check("reset.mem_wdata", bus.mem_wdata,         32'd0);
        check("reset.mem_be",    {28'd0, bus.mem_be},   32'd0);
        check("reset.bus_err",   {31'd0, bus_err},      32'd0);
        check("reset.stall",     {31'd0, stall},        32'd0);
        rst = 1'b0;

        // Word load, ack on the third REQ cycle.
        do_access("lw", 1, 0, 2'b10, 0, 32'h100, 32'h0, 32'hDEADBEEF, 2,
                  32'h100, 4'b1111, 32'h0, 0, 32'hDEADBEEF, 0, 4);
        // Byte loads with sign/zero extension, minimum latency.
        do_access("lb3", 1, 0, 2'b00, 0, 32'h203, 32'h0, 32'h00F08000, 0,
                  32'h200, 4'b1000, 32'h0, 0, 32'h00000000, 0, 2);
        do_access("lb2", 1, 0, 2'b00, 0, 32'h202, 32'h0, 32'h00F08000, 0,
                  32'h200, 4'b0100, 32'h0, 0, 32'hFFFFFFF0, 0, 2);
        do_access("lbu2", 1, 0, 2'b00, 1, 32'h202, 32'h0, 32'h00F08000, 0,
                  32'h200, 4'b0100, 32'h0, 0, 32'h000000F0, 0, 2);
        // Half loads, upper signed and lower unsigned.
        do_access("lh_hi", 1, 0, 2'b01, 0, 32'h1E, 32'h0, 32'h80017FFF, 1,
                  32'h1C, 4'b1100, 32'h0, 0, 32'hFFFF8001, 0, 3);
        do_access("lhu_lo", 1, 0, 2'b01, 1, 32'h1C, 32'h0, 32'h80017FFF, 0,
                  32'h1C, 4'b0011, 32'h0, 0, 32'h00007FFF, 0, 2);
        // Stores leave rdata alone.
        do_access("sh", 0, 1, 2'b01, 0, 32'h1A, 32'h1234ABCD, 32'hFFFFFFFF, 0,
                  32'h18, 4'b1100, 32'hABCDABCD, 1, 32'h00007FFF, 0, 2);
        do_access("sb", 0, 1, 2'b00, 0, 32'h11, 32'h000000A5, 32'hFFFFFFFF, 1,
                  32'h10, 4'b0010, 32'hA5A5A5A5, 1, 32'h00007FFF, 0, 3);
        // memread and memwrite together behave as a store.
        do_access("rw_both", 1, 1, 2'b10, 0, 32'h40, 32'hCAFEF00D, 32'h11111111, 0,
                  32'h40, 4'b1111, 32'hCAFEF00D, 1, 32'h00007FFF, 0, 2);

        // Misaligned word load: no request, no stall, rdata untouched.
        @(negedge clk);
        memread  = 1'b1;
        mem_size = 2'b10;
        addr     = 32'h102;
        #1;
        check("mis_w.misaligned", {31'd0, misaligned}, 32'd1);
        check("mis_w.stall",      {31'd0, stall},      32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("mis_w.mem_req", {31'd0, bus.mem_req}, 32'd0);
            check("mis_w.rdata",   rdata,                32'h00007FFF);
        end
        mem_size = 2'b01;
        addr     = 32'h101;
        #1;
        check("mis_h.misaligned", {31'd0, misaligned}, 32'd1);
        memread = 1'b0;
        #1;
        check("mis_h.no_op", {31'd0, misaligned}, 32'd0);

        // Aligned half at offset 2 is legal.
        do_access("lh_off2", 1, 0, 2'b01, 1, 32'h102, 32'h0, 32'hBEEF0000, 0,
                  32'h100, 4'b1100, 32'h0, 0, 32'h0000BEEF, 0, 2);

        // Timeout: four REQ cycles, then bus_err with rdata cleared.
        do_access("lw_tmo", 1, 0, 2'b10, 0, 32'h300, 32'h0, 32'h55555555, -1,
                  32'h300, 4'b1111, 32'h0, 0, 32'h00000000, 1, 5);
        // Ack in the final allowed REQ cycle still completes.
        do_access("lw_last", 1, 0, 2'b10, 0, 32'h304, 32'h0, 32'h13572468, 3,
                  32'h304, 4'b1111, 32'h0, 0, 32'h13572468, 0, 5);
        // Store timeout flags bus_err but keeps rdata.
        do_access("sw_tmo", 0, 1, 2'b10, 0, 32'h308, 32'h0BADF00D, 32'h0, -1,
                  32'h308, 4'b1111, 32'h0BADF00D, 1, 32'h13572468, 1, 5);

        // Reset during REQ, then a stale ack, then a normal load.
        @(negedge clk);
        memread       = 1'b1;
        memwrite      = 1'b0;
        mem_size      = 2'b10;
        addr          = 32'h400;
        bus.mem_rdata = 32'h99999999;
        @(negedge clk);
        #1;
        check("rst_mid.req_before", {31'd0, bus.mem_req}, 32'd1);
        rst     = 1'b1;
        memread = 1'b0;
        @(negedge clk);
        #1;
        check("rst_mid.mem_req", {31'd0, bus.mem_req}, 32'd0);
        check("rst_mid.rdata",   rdata,                32'd0);
        check("rst_mid.stall",   {31'd0, stall},       32'd0);
        rst         = 1'b0;
        bus.mem_ack = 1'b1;
        @(negedge clk);
        #1;
        bus.mem_ack = 1'b0;
        check("late_ack.mem_req", {31'd0, bus.mem_req}, 32'd0);
        check("late_ack.rdata",   rdata,                32'd0);
        check("late_ack.bus_err", {31'd0, bus_err},     32'd0);
        do_access("lw_after_rst", 1, 0, 2'b10, 0, 32'h404, 32'h0, 32'h0F1E2D3C, 0,
                  32'h404, 4'b1111, 32'h0, 0, 32'h0F1E2D3C, 0, 2);

        check("scoreboard.empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
